// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared FSM states, owner codes and default geometry for the RAM port arbiter.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;
  localparam int RD_LAT_DEF = 1;

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner selection between the CPU and debug requesters.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the losing request is simply not granted and stays pending upstream.
// Ports: prio_dbg_i (only with RAM_ARB_ROUND_ROBIN_EN: 1 = debug wins a tie),
//        cpu_req_i/dbg_req_i requests, grant_vld_o any request, grant_dbg_o debug wins.
module ram_arb_pick (
`ifdef RAM_ARB_ROUND_ROBIN_EN
  input  logic prio_dbg_i,
`endif
  input  logic cpu_req_i,
  input  logic dbg_req_i,
  output logic grant_vld_o,
  output logic grant_dbg_o
);

  assign grant_vld_o = cpu_req_i | dbg_req_i;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // Debug wins when alone, or on a tie when the pointer says it is its turn.
  assign grant_dbg_o = dbg_req_i & (~cpu_req_i | prio_dbg_i);
`else
  // Fixed priority: CPU always wins a tie.
  assign grant_dbg_o = dbg_req_i & ~cpu_req_i;
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between the CPU MAR/MDR path and a debug/loader port.
// Latency: sample-to-done 1 cycle for writes, 1+RD_LAT cycles for reads; one access in flight.
// Backpressure: requests are held by the master until done; the loser waits, sampled only in IDLE.
// Ports: Clock/Reset (async, active-high); cpu_* and dbg_* request ports with registered
//        *_rdata and one-cycle *_done; owner_dbg; ram_* command/data towards the RAM macro.
// Option: define RAM_ARB_ROUND_ROBIN_EN for alternating tie-break, otherwise CPU has fixed priority.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,
  output logic              owner_dbg,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  arb_state_e       state_q;
  logic             owner_q;
  logic             we_q;
  logic [CNT_W-1:0] cnt_q;
  logic             grant_vld;
  logic             grant_dbg;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic             prio_dbg_q;
`endif

  ram_arb_pick u_pick (
`ifdef RAM_ARB_ROUND_ROBIN_EN
    .prio_dbg_i  (prio_dbg_q),
`endif
    .cpu_req_i   (cpu_req),
    .dbg_req_i   (dbg_req),
    .grant_vld_o (grant_vld),
    .grant_dbg_o (grant_dbg)
  );

  // ram_addr/ram_wdata double as the transaction latches, so late changes on
  // the request ports cannot leak into an access already granted.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_CPU;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_we     <= 1'b0;
      ram_re     <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
      cpu_done   <= 1'b0;
      dbg_done   <= 1'b0;
      owner_dbg  <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      prio_dbg_q <= OWN_CPU;
`endif
    end else begin
      // Strobes and done pulses are single-cycle unless re-armed below.
      ram_we   <= 1'b0;
      ram_re   <= 1'b0;
      cpu_done <= 1'b0;
      dbg_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            owner_q   <= grant_dbg;
            owner_dbg <= grant_dbg;
            we_q      <= grant_dbg ? dbg_we    : cpu_we;
            ram_addr  <= grant_dbg ? dbg_addr  : cpu_addr;
            ram_wdata <= grant_dbg ? dbg_wdata : cpu_wdata;
            ram_we    <= grant_dbg ? dbg_we    : cpu_we;
            ram_re    <= grant_dbg ? ~dbg_we   : ~cpu_we;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            // Next tie goes to whoever did not just win.
            prio_dbg_q <= ~grant_dbg;
`endif
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (we_q) begin
            cpu_done <= (owner_q == OWN_CPU);
            dbg_done <= (owner_q == OWN_DBG);
            state_q  <= DONE;
          end else begin
            cnt_q   <= CNT_W'(RD_LAT);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            if (owner_q == OWN_DBG) begin
              dbg_rdata <= ram_rdata;
            end else begin
              cpu_rdata <= ram_rdata;
            end
            cpu_done <= (owner_q == OWN_CPU);
            dbg_done <= (owner_q == OWN_DBG);
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          owner_dbg <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
